add_sub_seq: RTL and testbench

Multi-cycle, parametrised adder/subtractor. It computes an N-bit add or subtract K bits per clock, with a valid/ready handshake on both sides and a registered carry/flag output. It is the sequential, area-reduced successor of the combinational ripple add/sub. It sits between an operand source and a result sink in datapath blocks where N is too wide for single-cycle ripple timing.

---
 rtl/add_sub_seq.sv | 165 ++++++++++++++++
 tb/tb_add_sub_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : add_sub_seq                                                |
// | Description : Multi-cycle N-bit adder/subtractor, K bits per clock, with |
// |               valid/ready handshakes on operand and result sides and     |
// |               registered sum / carry / overflow / zero outputs.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module add_sub_seq #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] s_o,
  output logic         c_o,
  output logic         v_o,
  output logic         z_o
);

  localparam int NCHUNK = N / K;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  // Reject illegal width/slice combinations at elaboration time.
  generate
    if ((N < 2) || (K < 1) || (K > N) || ((N % K) != 0)) begin : g_param_check
      $error("add_sub_seq: illegal parameters N=%0d K=%0d", N, K);
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q,   idx_d;
  logic [N-1:0]    a_q,     a_d;
  // B is stored already inverted for subtraction, so BUSY only ever adds.
  logic [N-1:0]    b_q,     b_d;
  logic            carry_q, carry_d;
  // Working sum, filled one chunk per cycle; kept apart from s_q so the
  // visible result does not change while a new operation is computing.
  logic [N-1:0]    res_q,   res_d;
  logic [N-1:0]    s_q,     s_d;
  logic            c_q,     c_d;
  logic            v_q,     v_d;
  logic            z_q,     z_d;

  logic [K-1:0]    a_chunk;
  logic [K-1:0]    b_chunk;
  logic [K:0]      chunk_sum;
  logic [N-1:0]    res_next;
  logic            last_chunk;

  // K-bit slice adder: the only carry chain that lives within one cycle.
  always_comb begin
    a_chunk    = a_q[int'(idx_q) * K +: K];
    b_chunk    = b_q[int'(idx_q) * K +: K];
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{K{1'b0}}, carry_q};
    res_next   = res_q;
    res_next[int'(idx_q) * K +: K] = chunk_sum[K-1:0];
    last_chunk = (idx_q == LAST_IDX);
  end

  // Control FSM plus next-state of all datapath registers.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    res_d       = res_q;
    s_d         = s_q;
    c_d         = c_q;
    v_d         = v_q;
    z_d         = z_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i ^ {N{op_i}};
          // Subtract is a + ~b + 1 with borrow-in folded into that +1.
          carry_d = c_i ^ op_i;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        res_d   = res_next;
        carry_d = chunk_sum[K];
        idx_d   = idx_q + IDXW'(1);
        if (last_chunk) begin
          idx_d   = '0;
          s_d     = res_next;
          c_d     = chunk_sum[K];
          // Like-signed operands producing an opposite-signed result.
          v_d     = (a_q[N-1] == b_q[N-1]) && (res_next[N-1] != a_q[N-1]);
          z_d     = ~|res_next;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      s_q     <= s_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign s_o = s_q;
  assign c_o = c_q;
  assign v_o = v_q;
  assign z_o = z_q;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_add_sub_seq                                             |
// | Description : Self-checking bench for add_sub_seq (N=16, K=4) against an |
// |               integer-arithmetic reference model.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_add_sub_seq;

  logic        clk_i;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        op_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        c_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] s_o;
  logic        c_o;
  logic        v_o;
  logic        z_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  add_sub_seq #(.N(16), .K(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .c_i         (c_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .s_o         (s_o),
    .c_o         (c_o),
    .v_o         (v_o),
    .z_o         (z_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: plain integer arithmetic. Result packed as {c, v, z, s}.
  function automatic logic [18:0] model(input logic op, input logic [15:0] a,
                                        input logic [15:0] b, input logic c);
    int ua, ub, sa, sb, ur, sr;
    logic [15:0] s;
    logic co, v, z;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!op) begin
      ur = ua + ub + int'(c);
      sr = sa + sb + int'(c);
      co = (ur > 65535);
    end else begin
      ur = ua - ub - int'(c);
      sr = sa - sb - int'(c);
      co = (ur >= 0);
    end
    s = ur[15:0];
    v = (sr > 32767) || (sr < -32768);
    z = (s == 16'h0000);
    return {co, v, z, s};
  endfunction

  // Drives one operation through both handshakes; result sampled after `hold`
  // cycles of output backpressure. Input pins are scrambled right after accept.
  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input int hold,
                        output logic [18:0] got, output int lat, output bit timeout);
    int w;
    timeout = 1'b0;
    w = 0;
    while (!in_ready_o && w < 50) begin
      @(posedge clk_i); #1; w++;
    end
    if (!in_ready_o) timeout = 1'b1;
    in_valid_i = 1'b1; op_i = op; a_i = a; b_i = b; c_i = c;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    op_i = 1'($urandom); a_i = 16'($urandom); b_i = 16'($urandom); c_i = 1'($urandom);
    lat = 0;
    while (!out_valid_o && lat < 50) begin
      @(posedge clk_i); #1; lat++;
    end
    if (!out_valid_o) timeout = 1'b1;
    repeat (hold) begin
      @(posedge clk_i); #1;
    end
    got = {c_o, v_o, z_o, s_o};
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    total_cnt++;
    if ({in_ready_o, out_valid_o, c_o, v_o, z_o, s_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      $display("FAIL reset_state: got rdy=%b vld=%b c=%b v=%b z=%b s=%h, expected rdy=1 vld=0 c=0 v=0 z=0 s=0000",
               in_ready_o, out_valid_o, c_o, v_o, z_o, s_o);
    end else pass_cnt++;
  endtask

  task automatic test_directed();
    logic        t_op [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] t_a  [6] = '{16'h7FFF, 16'hFFFF, 16'h0000, 16'h1234, 16'h8000, 16'h8000};
    logic [15:0] t_b  [6] = '{16'h0001, 16'h0000, 16'h0001, 16'h1234, 16'h0001, 16'h0001};
    logic        t_c  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    // expected {c, v, z, s}
    logic [18:0] t_e  [6] = '{{3'b010, 16'h8000}, {3'b101, 16'h0000}, {3'b000, 16'hFFFF},
                              {3'b101, 16'h0000}, {3'b110, 16'h7FFF}, {3'b110, 16'h7FFE}};
    logic [18:0] got;
    int lat;
    bit to;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_c[i], 0, got, lat, to);
      total_cnt++;
      if (to || lat !== 4) begin
        $display("FAIL directed_latency[%0d]: got %0d cycles (timeout=%0d), expected 4", i, lat, to);
      end else pass_cnt++;
      total_cnt++;
      if (got !== t_e[i]) begin
        $display("FAIL directed_result[%0d]: got c/v/z/s=%b%b%b/%h, expected %b%b%b/%h",
                 i, got[18], got[17], got[16], got[15:0], t_e[i][18], t_e[i][17], t_e[i][16], t_e[i][15:0]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] exp_r;
    int w;
    exp_r = model(1'b0, 16'h1111, 16'h2222, 1'b0);
    w = 0;
    while (!in_ready_o && w < 50) begin
      @(posedge clk_i); #1; w++;
    end
    in_valid_i = 1'b1; op_i = 1'b0; a_i = 16'h1111; b_i = 16'h2222; c_i = 1'b0;
    @(posedge clk_i); #1;
    // Keep offering garbage operands through BUSY and DONE; none may be taken.
    w = 0;
    while (!out_valid_o && w < 50) begin
      op_i = 1'($urandom); a_i = 16'($urandom); b_i = 16'($urandom); c_i = 1'($urandom);
      @(posedge clk_i); #1; w++;
    end
    total_cnt++;
    if (!out_valid_o) begin
      $display("FAIL bp_reach_done: got out_valid=%b after %0d cycles, expected 1", out_valid_o, w);
    end else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      op_i = 1'($urandom); a_i = 16'($urandom); b_i = 16'($urandom); c_i = 1'($urandom);
      total_cnt++;
      if ({out_valid_o, in_ready_o, c_o, v_o, z_o, s_o} !== {2'b10, exp_r}) begin
        $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b c/v/z/s=%b%b%b/%h, expected vld=1 rdy=0 %b%b%b/%h",
                 i, out_valid_o, in_ready_o, c_o, v_o, z_o, s_o, exp_r[18], exp_r[17], exp_r[16], exp_r[15:0]);
      end else pass_cnt++;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    total_cnt++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      $display("FAIL bp_release: got vld=%b rdy=%b, expected vld=0 rdy=1", out_valid_o, in_ready_o);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    logic [18:0] got;
    int lat;
    bit to;
    bit seen;
    in_valid_i = 1'b1; op_i = 1'b0; a_i = 16'h4321; b_i = 16'h1111; c_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    total_cnt++;
    if ({in_ready_o, out_valid_o, c_o, v_o, z_o, s_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      $display("FAIL rst_mid_busy: got rdy=%b vld=%b c=%b v=%b z=%b s=%h, expected rdy=1 vld=0 c=0 v=0 z=0 s=0000",
               in_ready_o, out_valid_o, c_o, v_o, z_o, s_o);
    end else pass_cnt++;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk_i); #1;
      if (out_valid_o || !in_ready_o) seen = 1'b1;
    end
    total_cnt++;
    if (seen) begin
      $display("FAIL rst_aborted: got a resumed operation (vld/busy seen=1), expected 0");
    end else pass_cnt++;
    run_op(1'b0, 16'h0003, 16'h0004, 1'b0, 0, got, lat, to);
    total_cnt++;
    if (to || got !== {3'b000, 16'h0007}) begin
      $display("FAIL rst_next_op: got c/v/z/s=%b%b%b/%h (timeout=%0d), expected 000/0007",
               got[18], got[17], got[16], got[15:0], to);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [18:0] q[$];
    int acc[$];
    int cyc;
    int done;
    logic [18:0] e;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    cyc = 0;
    done = 0;
    while (done < 5 && cyc < 200) begin
      if (out_valid_o) begin
        total_cnt++;
        if (q.size() == 0) begin
          $display("FAIL b2b_result: got unexpected result %h, expected none pending", s_o);
        end else begin
          e = q.pop_front();
          if ({c_o, v_o, z_o, s_o} !== e) begin
            $display("FAIL b2b_result[%0d]: got c/v/z/s=%b%b%b/%h, expected %b%b%b/%h",
                     done, c_o, v_o, z_o, s_o, e[18], e[17], e[16], e[15:0]);
          end else pass_cnt++;
        end
        done++;
      end
      if (in_ready_o) begin
        op_i = 1'($urandom); a_i = 16'($urandom); b_i = 16'($urandom); c_i = 1'($urandom);
        q.push_back(model(op_i, a_i, b_i, c_i));
        acc.push_back(cyc);
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    total_cnt++;
    if (done !== 5) begin
      $display("FAIL b2b_count: got %0d results in %0d cycles, expected 5", done, cyc);
    end else pass_cnt++;
    for (int i = 1; i < acc.size(); i++) begin
      total_cnt++;
      if (acc[i] - acc[i-1] !== 6) begin
        $display("FAIL b2b_interval[%0d]: got %0d cycles, expected 6", i, acc[i] - acc[i-1]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [18:0] got;
    logic [18:0] e;
    logic        op, c;
    logic [15:0] a, b;
    int lat;
    bit to;
    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom);
      c  = 1'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      // Bias some operands toward the sign/carry boundaries.
      if (i % 5 == 0) a = {a[15], 15'h7FFF};
      if (i % 7 == 0) b = {b[15], 15'h0000};
      e = model(op, a, b, c);
      run_op(op, a, b, c, int'($urandom_range(0, 3)), got, lat, to);
      total_cnt++;
      if (to || lat !== 4 || got !== e) begin
        $display("FAIL random[%0d]: op=%b a=%h b=%h ci=%b got c/v/z/s=%b%b%b/%h lat=%0d, expected %b%b%b/%h lat=4",
                 i, op, a, b, c, got[18], got[17], got[16], got[15:0], lat, e[18], e[17], e[16], e[15:0]);
      end else pass_cnt++;
    end
  endtask

  initial begin
    rst_i = 1'b0; in_valid_i = 1'b0; op_i = 1'b0; a_i = '0; b_i = '0; c_i = 1'b0;
    out_ready_i = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
